// File: rtl/cpu_pkg.sv
// Shared memory-stage definitions: FSM state type, IO address map and RAM geometry.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [31:0] IO_BASE_MASK = 32'hFFFF_FC00;
  localparam logic [31:0] LED_ADDR     = 32'hFFFF_FC60;
  localparam logic [31:0] SWITCH_ADDR  = 32'hFFFF_FC70;
  localparam int          RAM_ADDR_W   = 14;

  // IO space is the top 1 KB of the address map.
  function automatic logic is_io(input logic [31:0] addr);
    return (addr & IO_BASE_MASK) == IO_BASE_MASK;
  endfunction

endpackage

// File: rtl/mem_stage32_io.sv
// Board IO for the memory stage: LED register, two-flop switch synchroniser
// and the IO read mux. Decodes word addresses, so the byte offset never reaches it.
module mem_stage32_io
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        rst_n,
  input  logic [31:2] word_addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [23:0] wdata,
  input  logic [23:0] switch_in,
  output logic [23:0] led_out,
  output logic [31:0] rdata
);

  logic [23:0] sw_meta;
  logic [23:0] sw_sync;
  logic        led_hit;
  logic        sw_hit;

  assign led_hit = (word_addr == LED_ADDR[31:2]);
  assign sw_hit  = (word_addr == SWITCH_ADDR[31:2]);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
    end else if (wr_en && led_hit) begin
      led_out <= wdata;
    end
  end

  // Unmapped IO reads fall through to zero.
  always_comb begin
    rdata = '0;
    if (rd_en && sw_hit) begin
      rdata = {8'h00, sw_sync};
    end
  end

endmodule

// File: rtl/mem_stage32.sv
// MIPS-style memory stage: stalls the pipeline around a handshaked data RAM and
// serves board IO with no stall. Define MISALIGN_TRAP_EN to add the Addr_Err trap.
module mem_stage32
  import cpu_pkg::*;
(
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [31:0]           ALU_Result,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           Write_data,
  output logic [31:0]           Read_data,
  output logic                  Stall,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  input  logic                  ram_ack,
  input  logic [23:0]           switch_in,
  output logic [23:0]           led_out
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                  Addr_Err
`endif
);

  mem_state_t  state;
  mem_state_t  state_next;
  logic        access;
  logic        misaligned;
  logic        io_sel;
  logic        io_wr;
  logic        io_rd;
  logic        capture;
  logic [31:0] io_rdata;
  logic [31:0] rdata_q;

  assign access = MemRead | MemWrite;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = access && (ALU_Result[1:0] != 2'b00);
  assign Addr_Err   = rst_n && (state == IDLE) && misaligned;
`else
  logic unused_byte_offset;
  assign misaligned         = 1'b0;
  assign unused_byte_offset = ^ALU_Result[1:0];
`endif

  // A write wins when both MemRead and MemWrite are raised.
  assign io_sel = (state == IDLE) && access && !misaligned && is_io(ALU_Result);
  assign io_wr  = io_sel && MemWrite;
  assign io_rd  = io_sel && !MemWrite;

  mem_stage32_io u_io (
    .clock     (clock),
    .rst_n     (rst_n),
    .word_addr (ALU_Result[31:2]),
    .wr_en     (io_wr),
    .rd_en     (io_rd),
    .wdata     (Write_data[23:0]),
    .switch_in (switch_in),
    .led_out   (led_out),
    .rdata     (io_rdata)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stall in IDLE is gated by rst_n so a pending access cannot stall during reset.
  always_comb begin
    state_next = state;
    Stall      = 1'b0;
    ram_req    = 1'b0;
    capture    = 1'b0;
    Read_data  = '0;
    unique case (state)
      IDLE: begin
        Read_data = io_rdata;
        if (access && !misaligned && !is_io(ALU_Result)) begin
          capture    = 1'b1;
          Stall      = rst_n;
          state_next = WAIT;
        end
      end
      WAIT: begin
        ram_req = 1'b1;
        Stall   = 1'b1;
        if (ram_ack) begin
          state_next = DONE;
        end
      end
      DONE: begin
        Read_data  = rdata_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are frozen from capture until the next access, keeping them stable in WAIT.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (capture) begin
        ram_addr  <= ALU_Result[RAM_ADDR_W+1:2];
        ram_wdata <= Write_data;
        ram_we    <= MemWrite;
      end
      if ((state == WAIT) && ram_ack) begin
        rdata_q <= ram_we ? 32'h0 : ram_rdata;
      end
    end
  end

endmodule
